// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for a classic five-stage in-order core.
// Resolves RAW and load-use hazards by forwarding or stalling, inserts
// flush bubbles on taken branches, freezes the whole pipeline while the
// data memory inserts wait cycles, and keeps saturating counters of
// stall and flush cycles.
module pipeline_hazard_ctrl #(
   parameter int REG_W        = 5,
   parameter int FWD_EN       = 1,
   parameter int BRANCH_STAGE = 3,
   parameter int MEM_LAT      = 0,
   parameter int CNT_W        = 16
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [REG_W-1:0] ex_rs1,
   input  logic [REG_W-1:0] ex_rs2,
   input  logic [REG_W-1:0] ex_rd,
   input  logic [REG_W-1:0] mem_rd,
   input  logic [REG_W-1:0] wb_rd,
   input  logic             ex_reg_write,
   input  logic             mem_reg_write,
   input  logic             wb_reg_write,
   input  logic             ex_mem_read,
   input  logic             mem_access,
   input  logic             branch_taken,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             ex_mem_bubble,
   output logic             pipe_freeze,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // Memory-wait FSM encoding
   localparam logic [0:0] ST_RUN      = 1'b0;
   localparam logic [0:0] ST_MEM_WAIT = 1'b1;

   // Wait cycles still owed after the first frozen cycle of an access
   localparam logic [3:0] LAT_M1    = 4'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);
   localparam bit         LAT_ON    = (MEM_LAT > 0);
   localparam bit         LAT_MULTI = (MEM_LAT > 1);
   localparam bit         FWD_ON    = (FWD_EN != 0);
   localparam bit         BR_IN_MEM = (BRANCH_STAGE == 3);

   // A producer matches a source only if it really writes a non-x0 register
   function automatic logic hit(input logic [REG_W-1:0] rd,
                                input logic             we,
                                input logic [REG_W-1:0] src);
      return we && (rd != '0) && (rd == src);
   endfunction

   logic [0:0]       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             served_q, served_d;
   logic             freeze_c;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, wb_hit1, wb_hit2;
   logic raw_stall, load_use;

   assign ex_hit1  = hit(ex_rd,  ex_reg_write,  id_rs1);
   assign ex_hit2  = hit(ex_rd,  ex_reg_write,  id_rs2);
   assign mem_hit1 = hit(mem_rd, mem_reg_write, id_rs1);
   assign mem_hit2 = hit(mem_rd, mem_reg_write, id_rs2);
   assign wb_hit1  = hit(wb_rd,  wb_reg_write,  id_rs1);
   assign wb_hit2  = hit(wb_rd,  wb_reg_write,  id_rs2);

   // Without forwarding any in-flight producer of a used ID source blocks issue
   assign raw_stall = !FWD_ON &&
                      ((id_use_rs1 && (ex_hit1 || mem_hit1 || wb_hit1)) ||
                       (id_use_rs2 && (ex_hit2 || mem_hit2 || wb_hit2)));

   // A load's data is not ready for forwarding until it leaves MEM
   assign load_use = ex_mem_read &&
                     ((id_use_rs1 && ex_hit1) || (id_use_rs2 && ex_hit2));

   // EX operand selects: the youngest producer (EX/MEM) wins over MEM/WB
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (FWD_ON && RESET_N) begin
         if (hit(mem_rd, mem_reg_write, ex_rs1))     fwd_a = 2'b10;
         else if (hit(wb_rd, wb_reg_write, ex_rs1))  fwd_a = 2'b01;
         if (hit(mem_rd, mem_reg_write, ex_rs2))     fwd_b = 2'b10;
         else if (hit(wb_rd, wb_reg_write, ex_rs2))  fwd_b = 2'b01;
      end
   end

   // Memory-wait FSM: freeze MEM_LAT cycles per access, then let it advance
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned; otherwise synthesis infers a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      served_d = served_q;
      freeze_c = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (mem_access && !served_q && LAT_ON) begin
               freeze_c = 1'b1;
               if (LAT_MULTI) begin
                  state_d = ST_MEM_WAIT;
                  cnt_d   = LAT_M1;
               end else begin
                  served_d = 1'b1;
               end
            end else begin
               // The served access has advanced; the next one must wait again
               served_d = 1'b0;
            end
         end
         ST_MEM_WAIT: begin
            freeze_c = 1'b1;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == 4'd1) begin
               state_d  = ST_RUN;
               served_d = 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Pipeline control with priority freeze > branch flush > data stall
   always_comb begin
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_bubble  = 1'b0;
      ex_mem_bubble = 1'b0;
      pipe_freeze   = 1'b0;
      if (RESET_N) begin
         if (freeze_c) begin
            // A held branch stays in the frozen stage and is acted on later
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
         end else if (branch_taken) begin
            // Younger instructions are squashed, so a coincident stall is moot
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_bubble = BR_IN_MEM;
         end else if (raw_stall || load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
         end
      end
   end

   // FSM state registers
   always_ff @(posedge CLK or negedge RESET_N) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (!RESET_N) begin
         state_q  <= ST_RUN;
         cnt_q    <= 4'd0;
         served_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         served_q <= served_d;
      end
   end

   // Saturating performance counters for stall and flush cycles
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if ((pipe_freeze || !pc_write) && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 1'b1;
         if (if_id_flush && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl. Two instances share one
// stimulus stream: A forwards, resolves branches in MEM, waits 3 memory
// cycles; B stalls on RAW, resolves in EX, waits 8 cycles and has 4-bit
// counters so saturation is reached. A cycle-level reference model pushes
// expected outputs into per-instance queues; a monitor pops and compares
// on every falling edge.
module tb_pipeline_hazard_ctrl;

   localparam int REG_W = 5;
   localparam int A_FWD = 1, A_BR = 3, A_LAT = 3, A_CW = 16;
   localparam int B_FWD = 0, B_BR = 2, B_LAT = 8, B_CW = 4;

   typedef struct {
      logic [REG_W-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
      logic id_use_rs1, id_use_rs2, ex_reg_write, mem_reg_write, wb_reg_write;
      logic ex_mem_read, mem_access, branch_taken;
   } stim_t;

   typedef struct {
      bit       pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_bubble, pipe_freeze;
      bit [1:0] fwd_a, fwd_b;
      int       stall_cnt, flush_cnt;
   } exp_t;

   // Reference state: cycles of freeze still owed, and whether the access
   // currently sitting in MEM has already had its wait
   typedef struct {
      int freeze_left;
      bit served;
      int stall_cnt;
      int flush_cnt;
   } mstate_t;

   logic CLK = 1'b0;
   logic RESET_N = 1'b0;
   logic [REG_W-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic id_use_rs1, id_use_rs2, ex_reg_write, mem_reg_write, wb_reg_write;
   logic ex_mem_read, mem_access, branch_taken;

   logic a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_bubble, a_ex_mem_bubble, a_pipe_freeze;
   logic [1:0] a_fwd_a, a_fwd_b;
   logic [A_CW-1:0] a_stall_cnt, a_flush_cnt;
   logic b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_bubble, b_ex_mem_bubble, b_pipe_freeze;
   logic [1:0] b_fwd_a, b_fwd_b;
   logic [B_CW-1:0] b_stall_cnt, b_flush_cnt;

   exp_t    qa[$];
   exp_t    qb[$];
   mstate_t ma, mb;
   int      n_checks = 0;
   int      n_fail = 0;

   always #5 CLK = ~CLK;

   pipeline_hazard_ctrl #(.REG_W(REG_W), .FWD_EN(A_FWD), .BRANCH_STAGE(A_BR),
                          .MEM_LAT(A_LAT), .CNT_W(A_CW)) u_dut_a (
      .CLK(CLK), .RESET_N(RESET_N),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
      .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
      .ex_mem_read(ex_mem_read), .mem_access(mem_access), .branch_taken(branch_taken),
      .pc_write(a_pc_write), .if_id_write(a_if_id_write), .if_id_flush(a_if_id_flush),
      .id_ex_bubble(a_id_ex_bubble), .ex_mem_bubble(a_ex_mem_bubble), .pipe_freeze(a_pipe_freeze),
      .fwd_a(a_fwd_a), .fwd_b(a_fwd_b), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
   );

   pipeline_hazard_ctrl #(.REG_W(REG_W), .FWD_EN(B_FWD), .BRANCH_STAGE(B_BR),
                          .MEM_LAT(B_LAT), .CNT_W(B_CW)) u_dut_b (
      .CLK(CLK), .RESET_N(RESET_N),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
      .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
      .ex_mem_read(ex_mem_read), .mem_access(mem_access), .branch_taken(branch_taken),
      .pc_write(b_pc_write), .if_id_write(b_if_id_write), .if_id_flush(b_if_id_flush),
      .id_ex_bubble(b_id_ex_bubble), .ex_mem_bubble(b_ex_mem_bubble), .pipe_freeze(b_pipe_freeze),
      .fwd_a(b_fwd_a), .fwd_b(b_fwd_b), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit writes(input logic [REG_W-1:0] rd, input logic we,
                                 input logic [REG_W-1:0] src);
      return (we === 1'b1) && (rd != 0) && (rd == src);
   endfunction

   function automatic exp_t idle_exp();
      exp_t e;
      e = '{default: 0};
      e.pc_write    = 1'b1;
      e.if_id_write = 1'b1;
      return e;
   endfunction

   // One clock cycle of the reference behaviour, straight from the rules
   task automatic model_step(input stim_t s, input int fwd_en, input int br_stage,
                             input int lat, input int cnt_w,
                             inout mstate_t m, output exp_t e);
      bit fr, raw, lu, dep1, dep2;
      int cmax;
      cmax = (1 << cnt_w) - 1;
      e = idle_exp();
      e.stall_cnt = m.stall_cnt;
      e.flush_cnt = m.flush_cnt;
      // memory waits: a new access costs lat frozen cycles, then advances
      if (m.freeze_left == 0 && s.mem_access && !m.served && lat > 0)
         m.freeze_left = lat;
      fr = (m.freeze_left > 0);
      if (fr) begin
         m.freeze_left--;
         m.served = (m.freeze_left == 0);
      end else begin
         m.served = 1'b0;
      end
      if (fwd_en != 0) begin
         e.fwd_a = writes(s.mem_rd, s.mem_reg_write, s.ex_rs1) ? 2'b10 :
                   writes(s.wb_rd, s.wb_reg_write, s.ex_rs1)   ? 2'b01 : 2'b00;
         e.fwd_b = writes(s.mem_rd, s.mem_reg_write, s.ex_rs2) ? 2'b10 :
                   writes(s.wb_rd, s.wb_reg_write, s.ex_rs2)   ? 2'b01 : 2'b00;
      end
      dep1 = writes(s.ex_rd, s.ex_reg_write, s.id_rs1) || writes(s.mem_rd, s.mem_reg_write, s.id_rs1) ||
             writes(s.wb_rd, s.wb_reg_write, s.id_rs1);
      dep2 = writes(s.ex_rd, s.ex_reg_write, s.id_rs2) || writes(s.mem_rd, s.mem_reg_write, s.id_rs2) ||
             writes(s.wb_rd, s.wb_reg_write, s.id_rs2);
      raw = (fwd_en == 0) && ((s.id_use_rs1 && dep1) || (s.id_use_rs2 && dep2));
      lu  = s.ex_mem_read && ((s.id_use_rs1 && writes(s.ex_rd, s.ex_reg_write, s.id_rs1)) ||
                              (s.id_use_rs2 && writes(s.ex_rd, s.ex_reg_write, s.id_rs2)));
      if (fr) begin
         e.pipe_freeze = 1'b1;
         e.pc_write    = 1'b0;
         e.if_id_write = 1'b0;
      end else if (s.branch_taken) begin
         e.if_id_flush   = 1'b1;
         e.id_ex_bubble  = 1'b1;
         e.ex_mem_bubble = (br_stage == 3);
      end else if (raw || lu) begin
         e.pc_write     = 1'b0;
         e.if_id_write  = 1'b0;
         e.id_ex_bubble = 1'b1;
      end
      if ((fr || !e.pc_write) && m.stall_cnt < cmax) m.stall_cnt++;
      if (e.if_id_flush && m.flush_cnt < cmax) m.flush_cnt++;
   endtask

   task automatic drive(input stim_t s);
      id_rs1 = s.id_rs1;   id_rs2 = s.id_rs2;
      id_use_rs1 = s.id_use_rs1;   id_use_rs2 = s.id_use_rs2;
      ex_rs1 = s.ex_rs1;   ex_rs2 = s.ex_rs2;
      ex_rd = s.ex_rd;   mem_rd = s.mem_rd;   wb_rd = s.wb_rd;
      ex_reg_write = s.ex_reg_write;   mem_reg_write = s.mem_reg_write;
      wb_reg_write = s.wb_reg_write;   ex_mem_read = s.ex_mem_read;
      mem_access = s.mem_access;   branch_taken = s.branch_taken;
   endtask

   // One cycle: release any pending reset, apply inputs, queue the expectation.
   // With rst_pulse the reset is asserted mid-cycle and the model restarts.
   task automatic cycle(input stim_t s, input bit rst_pulse);
      exp_t e;
      @(posedge CLK);
      #1;
      RESET_N = 1'b1;
      drive(s);
      if (rst_pulse) begin
         #1;
         RESET_N = 1'b0;
         qa.push_back(idle_exp());
         qb.push_back(idle_exp());
         ma = '{default: 0};
         mb = '{default: 0};
      end else begin
         model_step(s, A_FWD, A_BR, A_LAT, A_CW, ma, e);
         qa.push_back(e);
         model_step(s, B_FWD, B_BR, B_LAT, B_CW, mb, e);
         qb.push_back(e);
      end
   endtask

   task automatic compare(input string tag, input exp_t e,
                          input logic pc, input logic ifid, input logic fl, input logic idex,
                          input logic exmem, input logic fr, input logic [1:0] fa,
                          input logic [1:0] fb, input logic [31:0] sc, input logic [31:0] fc);
      check({tag, ".pc_write"},      32'(pc),    32'(e.pc_write));
      check({tag, ".if_id_write"},   32'(ifid),  32'(e.if_id_write));
      check({tag, ".if_id_flush"},   32'(fl),    32'(e.if_id_flush));
      check({tag, ".id_ex_bubble"},  32'(idex),  32'(e.id_ex_bubble));
      check({tag, ".ex_mem_bubble"}, 32'(exmem), 32'(e.ex_mem_bubble));
      check({tag, ".pipe_freeze"},   32'(fr),    32'(e.pipe_freeze));
      check({tag, ".fwd_a"},         32'(fa),    32'(e.fwd_a));
      check({tag, ".fwd_b"},         32'(fb),    32'(e.fwd_b));
      check({tag, ".stall_cnt"},     sc,         32'(e.stall_cnt));
      check({tag, ".flush_cnt"},     fc,         32'(e.flush_cnt));
   endtask

   // Monitor: compare whatever the DUTs present against the queued expectation
   always @(negedge CLK) begin
      if (qa.size() > 0)
         compare("A", qa.pop_front(), a_pc_write, a_if_id_write, a_if_id_flush, a_id_ex_bubble,
                 a_ex_mem_bubble, a_pipe_freeze, a_fwd_a, a_fwd_b, 32'(a_stall_cnt), 32'(a_flush_cnt));
      if (qb.size() > 0)
         compare("B", qb.pop_front(), b_pc_write, b_if_id_write, b_if_id_flush, b_id_ex_bubble,
                 b_ex_mem_bubble, b_pipe_freeze, b_fwd_a, b_fwd_b, 32'(b_stall_cnt), 32'(b_flush_cnt));
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      stim_t    z, s;
      bit [7:0] pat;
      z = '{default: '0};
      ma = '{default: 0};
      mb = '{default: 0};
      drive(z);

      // Idle pipeline straight out of reset
      repeat (3) cycle(z, 1'b0);

      // Load-use: one stalled cycle, none when the load targets x0
      s = z;
      s.ex_mem_read = 1'b1;  s.ex_reg_write = 1'b1;  s.ex_rd = 5;
      s.id_rs1 = 5;          s.id_use_rs1 = 1'b1;
      cycle(s, 1'b0);  #2;
      check("lu_pc_write", 32'(a_pc_write), 0);
      check("lu_bubble", 32'(a_id_ex_bubble), 1);
      cycle(z, 1'b0);  #2;
      check("lu_released", 32'(a_pc_write), 1);
      s.ex_rd = 0;
      cycle(s, 1'b0);  #2;
      check("lu_x0_pc_write", 32'(a_pc_write), 1);
      check("lu_x0_bubble", 32'(a_id_ex_bubble), 0);

      // Forwarding priority, and RAW stall when forwarding is absent
      s = z;
      s.ex_rs1 = 7;  s.mem_rd = 7;  s.wb_rd = 7;
      s.mem_reg_write = 1'b1;  s.wb_reg_write = 1'b1;
      s.id_rs1 = 7;  s.id_use_rs1 = 1'b1;
      cycle(s, 1'b0);  #2;
      check("fwd_mem_first", 32'(a_fwd_a), 2);
      check("fwd_no_stall", 32'(a_pc_write), 1);
      check("nofwd_sel", 32'(b_fwd_a), 0);
      check("nofwd_raw_stall", 32'(b_pc_write), 0);
      s.mem_reg_write = 1'b0;
      cycle(s, 1'b0);  #2;
      check("fwd_wb", 32'(a_fwd_a), 1);

      // Memory wait: 3 frozen, 1 free, 3 frozen, 1 free; 6 stall cycles
      cycle(z, 1'b1);
      s = z;
      s.mem_access = 1'b1;
      pat = 8'b0111_0111;
      for (int i = 0; i < 8; i++) begin
         cycle(s, 1'b0);  #2;
         check($sformatf("memwait_freeze_%0d", i), 32'(a_pipe_freeze), 32'(pat[i]));
      end
      cycle(z, 1'b0);  #2;
      check("memwait_stall_cnt", 32'(a_stall_cnt), 6);

      // Branch beats a coincident load-use stall
      cycle(z, 1'b1);
      s = z;
      s.branch_taken = 1'b1;
      s.ex_mem_read = 1'b1;  s.ex_reg_write = 1'b1;  s.ex_rd = 5;
      s.id_rs1 = 5;          s.id_use_rs1 = 1'b1;
      cycle(s, 1'b0);  #2;
      check("br_if_id_flush", 32'(a_if_id_flush), 1);
      check("br_id_ex_bubble", 32'(a_id_ex_bubble), 1);
      check("br_ex_mem_bubble", 32'(a_ex_mem_bubble), 1);
      check("br_pc_write", 32'(a_pc_write), 1);
      check("br_ex_stage_no_ex_mem_bubble", 32'(b_ex_mem_bubble), 0);
      cycle(z, 1'b0);  #2;
      check("br_flush_cnt", 32'(a_flush_cnt), 1);
      check("br_stall_cnt", 32'(a_stall_cnt), 0);

      // Branch held during a freeze acts in the first unfrozen cycle
      cycle(z, 1'b1);
      s = z;
      s.mem_access = 1'b1;  s.branch_taken = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle(s, 1'b0);  #2;
         check($sformatf("held_branch_%0d", i), 32'(a_if_id_flush), 32'(i == 3));
      end
      cycle(z, 1'b0);

      // Reset in freeze cycle 4 of the 8-cycle instance, then a full new wait
      cycle(z, 1'b1);
      s = z;
      s.mem_access = 1'b1;
      repeat (3) cycle(s, 1'b0);
      cycle(s, 1'b1);  #1;
      check("rst_mid_freeze", 32'(b_pipe_freeze), 0);
      check("rst_stall_cnt", 32'(b_stall_cnt), 0);
      check("rst_flush_cnt", 32'(b_flush_cnt), 0);
      for (int i = 0; i < 9; i++) begin
         cycle(s, 1'b0);  #2;
         check($sformatf("post_rst_freeze_%0d", i), 32'(b_pipe_freeze), 32'(i < 8));
      end
      cycle(z, 1'b0);

      // Randomised traffic with rare resets; small register range forces matches
      for (int n = 0; n < 1500; n++) begin
         s.id_rs1 = REG_W'($urandom_range(0, 3));
         s.id_rs2 = REG_W'($urandom_range(0, 3));
         s.ex_rs1 = REG_W'($urandom_range(0, 3));
         s.ex_rs2 = REG_W'($urandom_range(0, 3));
         s.ex_rd  = REG_W'($urandom_range(0, 3));
         s.mem_rd = REG_W'($urandom_range(0, 3));
         s.wb_rd  = REG_W'($urandom_range(0, 3));
         s.id_use_rs1    = 1'($urandom_range(0, 1));
         s.id_use_rs2    = 1'($urandom_range(0, 1));
         s.ex_reg_write  = 1'($urandom_range(0, 1));
         s.mem_reg_write = 1'($urandom_range(0, 1));
         s.wb_reg_write  = 1'($urandom_range(0, 1));
         s.ex_mem_read   = ($urandom_range(0, 3) == 0);
         s.mem_access    = ($urandom_range(0, 7) == 0);
         s.branch_taken  = ($urandom_range(0, 5) == 0);
         cycle(s, ($urandom_range(0, 199) == 0));
      end

      cycle(z, 1'b0);
      repeat (2) @(posedge CLK);
      check("scoreboard_drained", 32'(qa.size() + qb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-index width.
REQ-002 SHALL have parameter FWD_EN, default 1; 1 means forwarding is enabled, 0 means RAW hazards are resolved by stalling.
REQ-003 SHALL have parameter BRANCH_STAGE, default 3; 2 means branches resolve in EX, 3 means branches resolve in MEM.
REQ-004 SHALL have parameter MEM_LAT, default 0, range 0..15; data-memory wait cycles per access.
REQ-005 SHALL have parameter CNT_W, default 16, performance-counter width.
REQ-006 SHALL have the following ports (name  direction  width  meaning):
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  reset; asynchronous, active-low.
- id_rs1, id_rs2  in  REG_W  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1  the instruction in ID reads that source.
- ex_rs1, ex_rs2  in  REG_W  source registers of the instruction in EX.
- ex_rd, mem_rd, wb_rd  in  REG_W  destination register per stage.
- ex_reg_write, mem_reg_write, wb_reg_write  in  1  stage writes rd.
- ex_mem_read  in  1  the instruction in EX is a load.
- mem_access  in  1  the instruction in MEM performs a load or store.
- branch_taken  in  1  taken branch in the resolution stage.
- pc_write, if_id_write  out  1  PC / IF_ID update enables.
- if_id_flush, id_ex_bubble, ex_mem_bubble  out  1  stage clear / NOP insert.
- pipe_freeze  out  1  hold all pipeline registers.
- fwd_a, fwd_b  out  2  EX operand select: 00 register file, 10 EX/MEM result, 01 MEM/WB result.
- stall_cnt, flush_cnt  out  CNT_W  saturating performance counters.

Function
REQ-007 SHALL treat register x0 as never matching; any match requires rd!=0 and the stage's reg_write=1.
REQ-008 SHALL, when FWD_EN=1, drive fwd_a=10 if the mem_rd match on ex_rs1 holds, else 01 if the wb_rd match holds, else 00; fwd_b SHALL follow the same rule on ex_rs2. Both selects are combinational.
REQ-009 SHALL, when FWD_EN=0, hold fwd_a=fwd_b=00 and raise a RAW stall whenever a used ID source matches ex_rd, mem_rd or wb_rd.
REQ-010 SHALL raise a load-use stall when ex_mem_read=1 and ex_rd matches a used ID source.
REQ-011 SHALL apply the following on a RAW or load-use stall, for 1 cycle per detection: pc_write=0, if_id_write=0, id_ex_bubble=1.
REQ-012 SHALL use an FSM with states RUN and MEM_WAIT, plus a 4-bit down-counter and a served flag.
REQ-013 SHALL, in RUN with mem_access=1, served=0 and MEM_LAT>0, assert pipe_freeze combinationally; if MEM_LAT>1 it SHALL go to MEM_WAIT with cnt=MEM_LAT-1, otherwise it SHALL set served.
REQ-014 SHALL, in MEM_WAIT, assert pipe_freeze and decrement cnt; when cnt==1 it SHALL return to RUN and set served.
REQ-015 SHALL freeze for exactly MEM_LAT consecutive cycles per access; the instruction then advances on the next cycle.
REQ-016 SHALL clear served after one cycle in RUN without freeze, so that back-to-back accesses each stall.
REQ-017 SHALL ignore mem_access while in MEM_WAIT.
REQ-018 SHALL, while pipe_freeze=1, drive pc_write=0 and if_id_write=0, and drive all flush and bubble outputs to 0.
REQ-019 SHALL, on branch_taken=1 with no freeze, drive if_id_flush=1, id_ex_bubble=1, pc_write=1, and ex_mem_bubble=1 only when BRANCH_STAGE=3.
REQ-020 SHALL apply the priority freeze > branch flush > RAW/load-use stall; a stall coincident with a flush is discarded.
REQ-021 SHALL treat a branch_taken that arrives during a freeze as held by the frozen pipeline and act on it in the first unfrozen cycle.
REQ-022 SHALL increment stall_cnt on each cycle with pipe_freeze=1 or pc_write=0, and increment flush_cnt on each flush cycle; both counters saturate at all-ones.
REQ-023 SHALL, with no hazard, drive pc_write=1, if_id_write=1, all flush/bubble/freeze outputs 0, and fwd_a=fwd_b=00.

Reset
REQ-024 SHALL, when RESET_N=0, immediately force state=RUN, cnt=0, served=0, stall_cnt=0 and flush_cnt=0, with the outputs at their REQ-023 values; this applies mid-freeze too.
REQ-025 SHALL restart operation on the first rising CLK edge after RESET_N deasserts.

Verification
REQ-026 SHALL be verified for load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> exactly 1 cycle with pc_write=0 and id_ex_bubble=1; the same stimulus with ex_rd=0 -> no stall.
REQ-027 SHALL be verified for forwarding priority: mem_rd=wb_rd=ex_rs1=7, both reg_write=1 -> fwd_a=10; with mem_reg_write=0 -> fwd_a=01; with FWD_EN=0 -> RAW stall and fwd_a=00.
REQ-028 SHALL be verified for memory wait: MEM_LAT=3 and mem_access held high -> pipe_freeze high for exactly 3 cycles, then low for 1 cycle; two back-to-back accesses -> 3+3 freeze cycles; stall_cnt=6.
REQ-029 SHALL be verified for branch: branch_taken=1 with BRANCH_STAGE=3 -> if_id_flush, id_ex_bubble and ex_mem_bubble all 1; branch and load-use in the same cycle -> flush only, pc_write=1, flush_cnt=1.
REQ-030 SHALL be verified for reset mid-freeze: MEM_LAT=8, RESET_N pulsed low at freeze cycle 4 -> pipe_freeze=0 and counters=0 immediately; a new access afterwards -> a full 8-cycle freeze.
